// File: rtl/dsp_mac_sequencer.sv
// Operand-feeding controller for a DSP slice: streams NTERMS operand pairs into A/B,
// gates the P register so it accumulates exactly those products, and returns the sum.
module dsp_mac_sequencer #(
    parameter int PIPE_LAT = 4,
    parameter int NT_W     = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [NT_W-1:0] NTERMS,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [17:0]     IN_A,
    input  logic [17:0]     IN_B,
    output logic [17:0]     DSP_A,
    output logic [17:0]     DSP_B,
    output logic [17:0]     DSP_D,
    output logic [7:0]      DSP_OPMODE,
    output logic            DSP_CEA,
    output logic            DSP_CEB,
    output logic            DSP_CEM,
    output logic            DSP_CEP,
    output logic            DSP_RSTP,
    input  logic [47:0]     DSP_P,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic [47:0]     RES_DATA,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NT_W:0]       nterms_r;
    logic [NT_W:0]       issued_r;
    logic [NT_W:0]       retired_r;
    logic [PIPE_LAT-1:0] tag_r;
    logic [17:0]         a_r;
    logic [17:0]         b_r;
    logic [47:0]         res_r;
    logic                hs_s;
    logic                last_hs_s;
    logic                drain_done_s;
    logic                start_job_s;
    logic                start_empty_s;

    // Handshake, job-start and completion qualifiers
    always_comb begin
        hs_s          = IN_VALID & (state_r == ST_ISSUE);
        last_hs_s     = hs_s & ((issued_r + {{NT_W{1'b0}}, 1'b1}) == nterms_r);
        drain_done_s  = (state_r == ST_DRAIN) & (retired_r == nterms_r);
        start_job_s   = (state_r == ST_IDLE) & START & (NTERMS != {NT_W{1'b0}});
        start_empty_s = (state_r == ST_IDLE) & START & (NTERMS == {NT_W{1'b0}});
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_job_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (start_empty_s) begin
                    state_nxt_s = ST_RESULT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_nxt_s = ST_ISSUE;
            ST_ISSUE: begin
                if (last_hs_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = ST_RESULT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_RESULT: begin
                if (RES_READY) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Job bookkeeping, operand registers, product tags and result capture
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            nterms_r  <= {(NT_W+1){1'b0}};
            issued_r  <= {(NT_W+1){1'b0}};
            retired_r <= {(NT_W+1){1'b0}};
            tag_r     <= {PIPE_LAT{1'b0}};
            a_r       <= 18'd0;
            b_r       <= 18'd0;
            res_r     <= 48'd0;
        end else begin
            if (start_job_s) begin
                nterms_r <= {1'b0, NTERMS};
            end else begin
                nterms_r <= nterms_r;
            end

            // Tags mark the cycles whose products belong to this job; stale operands never commit
            tag_r <= {tag_r[PIPE_LAT-2:0], hs_s};

            if (state_r == ST_CLEAR) begin
                issued_r <= {(NT_W+1){1'b0}};
            end else if (hs_s) begin
                issued_r <= issued_r + {{NT_W{1'b0}}, 1'b1};
            end else begin
                issued_r <= issued_r;
            end

            if (state_r == ST_CLEAR) begin
                retired_r <= {(NT_W+1){1'b0}};
            end else if (tag_r[PIPE_LAT-1]) begin
                retired_r <= retired_r + {{NT_W{1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end

            if (hs_s) begin
                a_r <= IN_A;
                b_r <= IN_B;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end

            if (start_empty_s) begin
                res_r <= 48'd0;
            end else if (drain_done_s) begin
                res_r <= DSP_P;
            end else begin
                res_r <= res_r;
            end
        end
    end

    // Output decode
    always_comb begin
        IN_READY   = (state_r == ST_ISSUE);
        BUSY       = (state_r != ST_IDLE);
        RES_VALID  = (state_r == ST_RESULT);
        RES_DATA   = res_r;
        DSP_A      = a_r;
        DSP_B      = b_r;
        DSP_D      = 18'd0;
        DSP_OPMODE = 8'h09;
        DSP_CEA    = (state_r != ST_IDLE);
        DSP_CEB    = (state_r != ST_IDLE);
        DSP_CEM    = (state_r != ST_IDLE);
        DSP_CEP    = tag_r[PIPE_LAT-1];
        DSP_RSTP   = ~RST_N | (state_r == ST_CLEAR);
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice closes the loop, jobs come from a
// vector table, and reset/backpressure corners are hand-written sequences.
module tb_dsp_mac_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [7:0]  NTERMS;
    logic        IN_VALID;
    logic        IN_READY;
    logic [17:0] IN_A;
    logic [17:0] IN_B;
    logic [17:0] DSP_A;
    logic [17:0] DSP_B;
    logic [17:0] DSP_D;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CEA;
    logic        DSP_CEB;
    logic        DSP_CEM;
    logic        DSP_CEP;
    logic        DSP_RSTP;
    logic [47:0] DSP_P;
    logic        RES_VALID;
    logic        RES_READY;
    logic [47:0] RES_DATA;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    dsp_mac_sequencer #(.PIPE_LAT(4), .NT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .NTERMS(NTERMS),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
        .DSP_RSTP(DSP_RSTP), .DSP_P(DSP_P), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Slice model: A/B two register stages, M register, P accumulator (operand-to-commit = 4 incl. the +1)
    logic [17:0] a1 = 18'd0, b1 = 18'd0, a2 = 18'd0, b2 = 18'd0;
    logic [35:0] m  = 36'd0;
    logic [47:0] p  = 48'd0;
    always @(posedge CLK) begin
        if (DSP_CEA) begin a1 <= DSP_A; a2 <= a1; end
        if (DSP_CEB) begin b1 <= DSP_B; b2 <= b1; end
        if (DSP_CEM) m <= 36'(a2) * 36'(b2);
        if (DSP_RSTP) p <= 48'd0;
        else if (DSP_CEP) p <= p + {12'd0, m};
    end
    assign DSP_P = p;

    typedef struct {
        int                n;
        logic [4:0][17:0]  a;
        logic [4:0][17:0]  b;
        int                gap;
        logic [47:0]       exp_sum;
        int                exp_lat;
        int                exp_cep;
        int                exp_rstp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one job from IDLE up to the first cycle RES_VALID is seen; RES_READY stays low
    task automatic run_job(input vec_t v, input string nm);
        int k, idx, gap_cnt, cep_n, rstp_n;
        bit done;
        @(negedge CLK);
        START  = 1'b1;
        NTERMS = 8'(v.n);
        @(posedge CLK);
        k = 0; idx = 0; gap_cnt = 0; cep_n = 0; rstp_n = 0; done = 1'b0;
        while (!done && k < 200) begin
            @(negedge CLK);
            START = 1'b0;
            if (RES_VALID) begin
                done = 1'b1;
            end else begin
                if (DSP_CEP)  cep_n++;
                if (DSP_RSTP) rstp_n++;
                if (gap_cnt > 0) begin
                    IN_VALID = 1'b0;
                    gap_cnt--;
                end else if (idx < v.n) begin
                    IN_VALID = 1'b1;
                    IN_A = v.a[idx];
                    IN_B = v.b[idx];
                    if (IN_READY) begin
                        idx++;
                        gap_cnt = v.gap;
                    end
                end else begin
                    IN_VALID = 1'b0;
                end
                @(posedge CLK);
                k++;
            end
        end
        IN_VALID = 1'b0;
        check({nm, " timeout"}, 48'(done), 48'd1);
        check({nm, " latency"}, 48'(k), 48'(v.exp_lat));
        check({nm, " res_data"}, RES_DATA, v.exp_sum);
        check({nm, " cep_count"}, 48'(cep_n), 48'(v.exp_cep));
        check({nm, " rstp_count"}, 48'(rstp_n), 48'(v.exp_rstp));
        check({nm, " busy_in_result"}, 48'(BUSY), 48'd1);
    endtask

    // Result handshake; the sequencer must be idle the next cycle with the data kept
    task automatic finish_result(input logic [47:0] exp_sum, input string nm);
        RES_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RES_READY = 1'b0;
        check({nm, " busy_after_hs"}, 48'(BUSY), 48'd0);
        check({nm, " valid_after_hs"}, 48'(RES_VALID), 48'd0);
        check({nm, " data_kept"}, RES_DATA, exp_sum);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; NTERMS = 8'd0; IN_VALID = 1'b0;
        IN_A = 18'd0; IN_B = 18'd0; RES_READY = 1'b0;

        vecs[0] = '{3, {18'd0, 18'd0, 18'd4, 18'd3, 18'd2}, {18'd0, 18'd0, 18'd7, 18'd6, 18'd5},
                    0, 48'd56, 9, 3, 1};
        vecs[1] = '{3, {18'd0, 18'd0, 18'd4, 18'd3, 18'd2}, {18'd0, 18'd0, 18'd7, 18'd6, 18'd5},
                    2, 48'd56, 13, 3, 1};
        vecs[2] = '{0, {5{18'd0}}, {5{18'd0}}, 0, 48'd0, 0, 0, 0};
        vecs[3] = '{4, {18'd0, {4{18'h3FFFF}}}, {18'd0, {4{18'h3FFFF}}},
                    0, 48'h003F_FFE0_0004, 10, 4, 1};
        vecs[4] = '{2, {18'd0, 18'd0, 18'd0, 18'd7, 18'd100}, {18'd0, 18'd0, 18'd0, 18'd9, 18'd200},
                    1, 48'd20063, 9, 2, 1};
        vecs[5] = '{1, {18'd0, 18'd0, 18'd0, 18'd0, 18'h3FFFF}, {18'd0, 18'd0, 18'd0, 18'd0, 18'h3FFFF},
                    0, 48'h000F_FFF8_0001, 7, 1, 1};

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst in_ready", 48'(IN_READY), 48'd0);
        check("rst res_valid", 48'(RES_VALID), 48'd0);
        check("rst res_data", RES_DATA, 48'd0);
        check("rst busy", 48'(BUSY), 48'd0);
        check("rst dsp_a", 48'(DSP_A), 48'd0);
        check("rst dsp_b", 48'(DSP_B), 48'd0);
        check("rst dsp_cep", 48'(DSP_CEP), 48'd0);
        check("rst dsp_rstp", 48'(DSP_RSTP), 48'd1);
        check("rst opmode", 48'(DSP_OPMODE), 48'h09);
        check("rst dsp_d", 48'(DSP_D), 48'd0);
        RST_N = 1'b1;

        // Continuous job, then result backpressure with START pulses that must be ignored
        run_job(vecs[0], "cont");
        for (int i = 0; i < 5; i++) begin
            START  = i[0];
            NTERMS = 8'd2;
            check("bp res_valid", 48'(RES_VALID), 48'd1);
            check("bp res_data", RES_DATA, 48'd56);
            check("bp busy", 48'(BUSY), 48'd1);
            @(posedge CLK);
            @(negedge CLK);
        end
        START = 1'b0;
        finish_result(48'd56, "bp");
        @(posedge CLK);
        @(negedge CLK);
        check("bp start_ignored", 48'(BUSY), 48'd0);

        // Table-driven jobs, each started right after the previous result handshake
        for (int v = 1; v < 5; v++) begin
            run_job(vecs[v], $sformatf("vec%0d", v));
            finish_result(vecs[v].exp_sum, $sformatf("vec%0d", v));
        end

        // Reset after 2 of 5 pairs, then a fresh single-term job
        @(negedge CLK);
        START = 1'b1; NTERMS = 8'd5;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0; IN_VALID = 1'b1; IN_A = 18'd1000; IN_B = 18'd1000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("midrst busy_before", 48'(BUSY), 48'd1);
        RST_N = 1'b0;
        #1;
        check("midrst rstp_low", 48'(DSP_RSTP), 48'd1);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        check("midrst busy", 48'(BUSY), 48'd0);
        check("midrst in_ready", 48'(IN_READY), 48'd0);
        check("midrst res_valid", 48'(RES_VALID), 48'd0);
        check("midrst res_data", RES_DATA, 48'd0);
        check("midrst dsp_a", 48'(DSP_A), 48'd0);
        check("midrst cep", 48'(DSP_CEP), 48'd0);
        repeat (6) begin
            @(posedge CLK);
            @(negedge CLK);
            check("midrst no_cep_idle", 48'(DSP_CEP), 48'd0);
        end
        run_job(vecs[5], "post_rst");
        finish_result(vecs[5].exp_sum, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
